microprocessor_sensor_pio: RTL and testbench



---
 rtl/microprocessor_sensor_pio.sv | 176 +++++++++++++++++
 tb/tb_microprocessor_sensor_pio.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/microprocessor_sensor_pio.sv
// Input-only Avalon-MM PIO: synchronised sensor lines, per-bit edge capture (W1C), masked level irq.
// Optional input debounce is compiled in with `define MICROPROCESSOR_SENSOR_PIO_DEBOUNCE_EN.
`timescale 1ns/1ps
module microprocessor_sensor_pio #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              chipselect,
  input  logic [1:0]        address,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  input  logic [WIDTH-1:0]  in_port,
  output logic [31:0]       readdata,
  output logic              irq
);

`ifdef MICROPROCESSOR_SENSOR_PIO_DEBOUNCE_EN
  localparam int DB_LAT = DEBOUNCE_CYCLES;
`else
  localparam int DB_LAT = 0;
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
`endif

  // Edge capture stays disabled until prev has loaded a settled input value.
  localparam int         WARM     = SYNC_STAGES + 1 + DB_LAT;
  localparam logic [8:0] WARM_END = 9'(WARM);

  logic [WIDTH-1:0] sync_r [SYNC_STAGES];
  logic [WIDTH-1:0] sync_in_s;
  logic [WIDTH-1:0] cond_in_s;
  logic [WIDTH-1:0] prev_r;
  logic [WIDTH-1:0] mask_r;
  logic [WIDTH-1:0] capture_r;
  logic [WIDTH-1:0] rise_s;
  logic [WIDTH-1:0] fall_s;
  logic [WIDTH-1:0] edge_s;
  logic [WIDTH-1:0] set_s;
  logic [WIDTH-1:0] clr_s;
  logic [8:0]       warm_r;
  logic             warm_done_s;
  logic             wr_s;
  logic [31:0]      rd_mux_s;
  logic             unused_writedata_s;

  assign wr_s               = chipselect & ~write_n;
  assign unused_writedata_s = ^writedata;

  // Synchroniser chain, one column of flops per input bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= {WIDTH{1'b0}};
    end else begin
      sync_r[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
    end
  end

  assign sync_in_s = sync_r[SYNC_STAGES-1];

`ifdef MICROPROCESSOR_SENSOR_PIO_DEBOUNCE_EN
  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic [7:0]       db_cnt_r [WIDTH];
  logic [WIDTH-1:0] cond_r;

  // Debounce: a bit only follows sync_in after it has differed from cond for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cond_r <= {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) db_cnt_r[i] <= 8'd0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_in_s[i] == cond_r[i]) begin
          db_cnt_r[i] <= 8'd0;
        end else if (db_cnt_r[i] == DB_LAST) begin
          cond_r[i]   <= sync_in_s[i];
          db_cnt_r[i] <= 8'd0;
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + 8'd1;
        end
      end
    end
  end

  assign cond_in_s = cond_r;
`else
  assign cond_in_s = sync_in_s;
`endif

  // Warm-up counter, saturates once capture is allowed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      warm_r <= 9'd0;
    end else if (warm_r != WARM_END) begin
      warm_r <= warm_r + 9'd1;
    end else begin
      warm_r <= warm_r;
    end
  end

  assign warm_done_s = (warm_r == WARM_END);
  assign rise_s      = cond_in_s & ~prev_r;
  assign fall_s      = ~cond_in_s & prev_r;

  // Edge polarity selection.
  always_comb begin
    edge_s = rise_s;
    case (EDGE_TYPE)
      0:       edge_s = rise_s;
      1:       edge_s = fall_s;
      2:       edge_s = rise_s ^ fall_s;
      default: edge_s = rise_s;
    endcase
  end

  // Set and clear requests for the capture register.
  always_comb begin
    set_s = {WIDTH{1'b0}};
    clr_s = {WIDTH{1'b0}};
    if (warm_done_s) begin
      set_s = edge_s;
    end else begin
      set_s = {WIDTH{1'b0}};
    end
    if (wr_s && (address == 2'd3)) begin
      clr_s = writedata[WIDTH-1:0];
    end else begin
      clr_s = {WIDTH{1'b0}};
    end
  end

  // Previous-value, mask and capture registers; a same-cycle set beats the clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_r    <= {WIDTH{1'b0}};
      mask_r    <= {WIDTH{1'b0}};
      capture_r <= {WIDTH{1'b0}};
    end else begin
      prev_r    <= cond_in_s;
      capture_r <= (capture_r & ~clr_s) | set_s;
      if (wr_s && (address == 2'd2)) begin
        mask_r <= writedata[WIDTH-1:0];
      end else begin
        mask_r <= mask_r;
      end
    end
  end

  // Read mux, zero-extended to the bus width.
  always_comb begin
    rd_mux_s = 32'd0;
    case (address)
      2'd0:    rd_mux_s[WIDTH-1:0] = cond_in_s;
      2'd1:    rd_mux_s = 32'd0;
      2'd2:    rd_mux_s[WIDTH-1:0] = mask_r;
      2'd3:    rd_mux_s[WIDTH-1:0] = capture_r;
      default: rd_mux_s = 32'd0;
    endcase
  end

  // Read data is registered every cycle with no read strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= 32'd0;
    end else begin
      readdata <= rd_mux_s;
    end
  end

  assign irq = |(capture_r & mask_r);

endmodule

// File: tb/tb_microprocessor_sensor_pio.sv
// Scoreboard bench for microprocessor_sensor_pio: a rising-edge instance and an any-edge instance share one bus.
`timescale 1ns/1ps
module tb_microprocessor_sensor_pio;

`ifdef MICROPROCESSOR_SENSOR_PIO_DEBOUNCE_EN
  localparam int LAT = 2 + 1 + 8;
`else
  localparam int LAT = 2 + 1;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        chipselect;
  logic [1:0]  address;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] rd_a;
  logic [31:0] rd_b;
  logic        irq_a;
  logic        irq_b;

  typedef struct {
    string       tag;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  microprocessor_sensor_pio #(.WIDTH(4), .SYNC_STAGES(2), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(8)) u_dut (
    .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .address(address),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_a), .irq(irq_a));

  microprocessor_sensor_pio #(.WIDTH(4), .SYNC_STAGES(2), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(8)) u_any (
    .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .address(address),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_b), .irq(irq_b));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] ea, input logic [31:0] eb, input string tag);
    exp_t e;
    address = a;
    e.tag   = tag;
    e.exp_a = ea;
    e.exp_b = eb;
    sb_q.push_back(e);
    tick();
    e = sb_q.pop_front();
    check_val({e.tag, "/rise"}, rd_a, e.exp_a);
    check_val({e.tag, "/any"},  rd_b, e.exp_b);
  endtask

  task automatic chk_irq(input logic ea, input logic eb, input string tag);
    check_val({tag, "/irq_rise"}, {31'd0, irq_a}, {31'd0, ea});
    check_val({tag, "/irq_any"},  {31'd0, irq_b}, {31'd0, eb});
  endtask

  initial begin
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = 32'd0;
    in_port    = 4'hF;
    repeat (3) tick();
    check_val("rst_rd_rise", rd_a, 32'd0);
    check_val("rst_rd_any",  rd_b, 32'd0);
    chk_irq(1'b0, 1'b0, "rst");

    // Static inputs through reset must not capture anything
    reset_n = 1'b1;
    repeat (LAT + 8) tick();
    rd(2'd0, 32'hF, 32'hF, "data_rst");
    rd(2'd3, 32'h0, 32'h0, "cap_rst");
    rd(2'd2, 32'h0, 32'h0, "mask_rst");
    rd(2'd1, 32'h0, 32'h0, "rsvd");
    chk_irq(1'b0, 1'b0, "post_rst");

    in_port = 4'h0;
    repeat (LAT + 1) tick();
    rd(2'd3, 32'h0, 32'hF, "fall_all");
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd3, 32'h0, 32'h0, "w1c_all");

    // Input-to-data latency
    in_port = 4'h5;
    for (int i = 0; i < LAT - 1; i++) rd(2'd0, 32'h0, 32'h0, "lat_early");
    rd(2'd0, 32'h5, 32'h5, "lat_first");
    rd(2'd3, 32'h5, 32'h5, "rise_02");
    wr(2'd3, 32'hF);

    in_port = 4'h0;
    repeat (LAT + 1) tick();
    wr(2'd3, 32'hF);
    rd(2'd3, 32'h0, 32'h0, "clr2");

    // Capture and masked interrupt
    wr(2'd2, 32'h4);
    chk_irq(1'b0, 1'b0, "mask_only");
    in_port = 4'h4;
    repeat (LAT + 1) tick();
    rd(2'd3, 32'h4, 32'h4, "cap_b2");
    chk_irq(1'b1, 1'b1, "cap_b2");
    in_port = 4'h5;
    repeat (LAT + 1) tick();
    rd(2'd3, 32'h5, 32'h5, "cap_b0");
    chk_irq(1'b1, 1'b1, "cap_b0");
    wr(2'd3, 32'h4);
    chk_irq(1'b0, 1'b0, "irq_clr");
    rd(2'd3, 32'h1, 32'h1, "cap_after_w1c");
    rd(2'd2, 32'h4, 32'h4, "mask_rb");
    wr(2'd2, 32'hFFFF_FFF1);
    chk_irq(1'b1, 1'b1, "mask_set");
    rd(2'd2, 32'h1, 32'h1, "mask_upper");
    wr(2'd2, 32'h0);
    chk_irq(1'b0, 1'b0, "mask_off");
    wr(2'd0, 32'hA);
    wr(2'd1, 32'hF);
    rd(2'd0, 32'h5, 32'h5, "data_ro");
    rd(2'd1, 32'h0, 32'h0, "rsvd_ro");

    // W1C lands on the same edge that sets bit 1
    in_port = 4'h7;
    repeat (LAT - 1) tick();
    wr(2'd3, 32'h2);
    rd(2'd3, 32'h3, 32'h3, "set_wins");
    wr(2'd3, 32'h1);
    rd(2'd3, 32'h2, 32'h2, "w1c_bit0");
    wr(2'd3, 32'hF);

    // Falling edge on bit 3: only the any-edge instance captures it
    in_port = 4'hF;
    repeat (LAT + 1) tick();
    rd(2'd3, 32'h8, 32'h8, "rise_b3");
    wr(2'd3, 32'hF);
    rd(2'd3, 32'h0, 32'h0, "clr3");
    in_port = 4'h7;
    repeat (LAT + 1) tick();
    rd(2'd3, 32'h0, 32'h8, "fall_b3");
    wr(2'd2, 32'h8);
    chk_irq(1'b0, 1'b1, "fall_irq");
    wr(2'd3, 32'hF);
    wr(2'd2, 32'h0);

    // Reset in the middle of operation
    in_port = 4'hF;
    repeat (LAT + 1) tick();
    wr(2'd2, 32'hF);
    chk_irq(1'b1, 1'b1, "pre_reset");
    reset_n = 1'b0;
    #1;
    check_val("midrst_rd_rise", rd_a, 32'd0);
    check_val("midrst_rd_any",  rd_b, 32'd0);
    chk_irq(1'b0, 1'b0, "midrst");
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (LAT + 8) tick();
    rd(2'd3, 32'h0, 32'h0, "warm_restart");
    rd(2'd2, 32'h0, 32'h0, "mask_restart");
    rd(2'd0, 32'hF, 32'hF, "data_restart");

`ifdef MICROPROCESSOR_SENSOR_PIO_DEBOUNCE_EN
    // Short glitch is filtered, a held level goes through
    in_port = 4'hE;
    repeat (LAT + 1) tick();
    wr(2'd3, 32'hF);
    in_port = 4'hF;
    repeat (5) tick();
    in_port = 4'hE;
    repeat (LAT + 5) tick();
    rd(2'd0, 32'hE, 32'hE, "glitch_data");
    rd(2'd3, 32'h0, 32'h0, "glitch_cap");
    in_port = 4'hF;
    repeat (LAT - 1) tick();
    rd(2'd0, 32'hF, 32'hF, "hold_data");
    rd(2'd3, 32'h1, 32'h1, "hold_cap");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
